// File: rtl/cache_nway_if.sv
// cache_nway_if: CPU request/response and AXI bridge signals of cache_nway.
interface cache_nway_if #(
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int OFFSET_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    logic                    valid;
    logic                    op;
    logic                    uncached;
    logic [INDEX_W-1:0]      index;
    logic [TAG_W-1:0]        tag;
    logic [OFFSET_W-1:0]     offset;
    logic [3:0]              wstrb;
    logic [31:0]             wdata;
    logic                    addr_ok;
    logic                    data_ok;
    logic [31:0]             rdata;
    logic                    rd_req;
    logic [2:0]              rd_type;
    logic [31:0]             rd_addr;
    logic                    rd_rdy;
    logic                    ret_valid;
    logic                    ret_last;
    logic [31:0]             ret_data;
    logic                    wr_req;
    logic [2:0]              wr_type;
    logic [31:0]             wr_addr;
    logic [3:0]              wr_wstrb;
    logic [32*LINE_WORDS-1:0] wr_data;
    logic                    wr_rdy;

    modport slave (
        input  valid, op, uncached, index, tag, offset, wstrb, wdata,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output addr_ok, data_ok, rdata,
        output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );

    modport master (
        output valid, op, uncached, index, tag, offset, wstrb, wdata,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  addr_ok, data_ok, rdata,
        input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );
endinterface

// File: rtl/cache_nway.sv
// cache_nway: set-associative write-back/write-allocate cache with a hit-store
// write buffer, LFSR replacement and an uncached bypass path.
module cache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    localparam int INDEX_W   = $clog2(SETS),
    localparam int OFFSET_W  = $clog2(LINE_WORDS) + 2,
    localparam int TAG_W     = 32 - INDEX_W - OFFSET_W
) (
    input logic clk,
    input logic resetn,
    cache_nway_if.slave bus
);
    localparam int WORD_W = OFFSET_W - 2;
    localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL} state_t;
    typedef enum logic {WR_IDLE, WR_WRITE} wr_state_t;

    state_t    state, state_nx;
    wr_state_t wr_state, wr_state_nx;

    logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
    logic [31:0]      data_arr [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]  v_arr    [WAYS];
    logic [SETS-1:0]  d_arr    [WAYS];

    logic                r_op, r_unc;
    logic [INDEX_W-1:0]  r_index;
    logic [TAG_W-1:0]    r_tag;
    logic [OFFSET_W-1:0] r_off;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_wdata;
    logic [WORD_W-1:0]   r_word;

    logic [WAY_W-1:0]    wb_way;
    logic [INDEX_W-1:0]  wb_index;
    logic [WORD_W-1:0]   wb_word;
    logic [3:0]          wb_wstrb;
    logic [31:0]         wb_wdata;

    logic [15:0]         lfsr;
    logic                lfsr_fb;
    logic [WAY_W-1:0]    victim;
    logic [WORD_W-1:0]   cnt;
    logic                wb_sent;

    logic [WAYS-1:0]     hit_w;
    logic [WAY_W-1:0]    hit_way;
    logic                hit, store_hit, conflict, refill_wr, refill_done;
    logic [WORD_W-1:0]   in_word;
    logic [TAG_W-1:0]    vic_tag;
    logic                vic_dirty;
    logic [LINE_W-1:0]   vic_line;
    logic [31:0]         ret_word;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return m;
    endfunction

    assign r_word  = r_off[OFFSET_W-1:2];
    assign in_word = bus.offset[OFFSET_W-1:2];
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        hit_w   = '0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_w[i] = v_arr[i][r_index] && tag_arr[i][r_index] == r_tag;
            if (hit_w[i]) hit_way = WAY_W'(i);
        end
    end

    assign hit       = |hit_w && !r_unc;
    assign store_hit = state == LOOKUP && hit && r_op;

    // Loads only: stores never wait on an in-flight store to the same word.
    assign conflict = bus.valid && !bus.op &&
        ((store_hit && bus.index == r_index && in_word == r_word) ||
         (wr_state == WR_WRITE && bus.index == wb_index && in_word == wb_word));

    assign vic_tag   = tag_arr[victim][r_index];
    assign vic_dirty = v_arr[victim][r_index] && d_arr[victim][r_index];

    always_comb begin
        vic_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) vic_line[i*32 +: 32] = data_arr[victim][r_index][i];
    end

    assign ret_word    = (r_op && cnt == r_word) ? merge(bus.ret_data, r_wdata, r_wstrb) : bus.ret_data;
    assign refill_wr   = state == REFILL && bus.ret_valid && !r_unc;
    assign refill_done = refill_wr && bus.ret_last;

    always_comb begin
        state_nx     = state;
        bus.addr_ok  = 1'b0;
        bus.data_ok  = 1'b0;
        bus.rdata    = '0;
        bus.rd_req   = 1'b0;
        bus.rd_type  = 3'b100;
        bus.rd_addr  = {r_tag, r_index, {OFFSET_W{1'b0}}};
        bus.wr_req   = 1'b0;
        bus.wr_type  = 3'b100;
        bus.wr_addr  = {vic_tag, r_index, {OFFSET_W{1'b0}}};
        bus.wr_wstrb = 4'hf;
        bus.wr_data  = vic_line;
        case (state)
            IDLE: begin
                bus.addr_ok = bus.valid && !conflict;
                state_nx    = bus.addr_ok ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = r_op ? 32'h0 : data_arr[hit_way][r_index][r_word];
                    bus.addr_ok = bus.valid && !conflict;
                    state_nx    = bus.addr_ok ? LOOKUP : IDLE;
                end else begin
                    state_nx = MISS;
                end
            end
            MISS: state_nx = (bus.wr_rdy && wr_state == WR_IDLE) ? REPLACE : MISS;
            REPLACE: begin
                if (r_unc && r_op) begin
                    bus.wr_req   = 1'b1;
                    bus.wr_type  = 3'b010;
                    bus.wr_addr  = {r_tag, r_index, r_off};
                    bus.wr_wstrb = r_wstrb;
                    bus.wr_data  = {{(LINE_W-32){1'b0}}, r_wdata};
                    bus.data_ok  = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    // Dirty write-back fires once even if rd_rdy keeps us here.
                    bus.wr_req  = !r_unc && vic_dirty && !wb_sent;
                    bus.rd_req  = 1'b1;
                    bus.rd_type = r_unc ? 3'b010 : 3'b100;
                    bus.rd_addr = r_unc ? {r_tag, r_index, r_off} : {r_tag, r_index, {OFFSET_W{1'b0}}};
                    state_nx    = bus.rd_rdy ? REFILL : REPLACE;
                end
            end
            REFILL: begin
                if (bus.ret_valid) begin
                    if (r_unc || (!r_op && cnt == r_word)) begin
                        bus.data_ok = 1'b1;
                        bus.rdata   = bus.ret_data;
                    end
                    if (bus.ret_last || r_unc) begin
                        bus.data_ok = bus.data_ok || r_op;
                        state_nx    = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wr_state_nx = store_hit ? WR_WRITE : WR_IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wr_state <= WR_IDLE;
            v_arr    <= '{default: '0};
            d_arr    <= '{default: '0};
            lfsr     <= 16'h1;
            victim   <= '0;
            cnt      <= '0;
            wb_sent  <= 1'b0;
            r_op     <= 1'b0;
            r_unc    <= 1'b0;
            r_index  <= '0;
            r_tag    <= '0;
            r_off    <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            wb_way   <= '0;
            wb_index <= '0;
            wb_word  <= '0;
            wb_wstrb <= '0;
            wb_wdata <= '0;
        end else begin
            state    <= state_nx;
            wr_state <= wr_state_nx;
            wb_sent  <= state == REPLACE;
            if (bus.addr_ok) begin
                r_op    <= bus.op;
                r_unc   <= bus.uncached;
                r_index <= bus.index;
                r_tag   <= bus.tag;
                r_off   <= bus.offset;
                r_wstrb <= bus.wstrb;
                r_wdata <= bus.wdata;
            end
            if (store_hit) begin
                wb_way   <= hit_way;
                wb_index <= r_index;
                wb_word  <= r_word;
                wb_wstrb <= r_wstrb;
                wb_wdata <= r_wdata;
            end
            if (state == LOOKUP && !hit) begin
                lfsr   <= {lfsr[14:0], lfsr_fb};
                victim <= WAY_W'(lfsr) & WAY_W'(WAYS - 1);
            end
            if (state == REFILL && bus.ret_valid) cnt <= (bus.ret_last || r_unc) ? '0 : cnt + 1'b1;
            if (wr_state == WR_WRITE) d_arr[wb_way][wb_index] <= 1'b1;
            if (refill_done) begin
                v_arr[victim][r_index] <= 1'b1;
                d_arr[victim][r_index] <= r_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_state == WR_WRITE)
            data_arr[wb_way][wb_index][wb_word] <= merge(data_arr[wb_way][wb_index][wb_word], wb_wdata, wb_wstrb);
        else if (refill_wr)
            data_arr[victim][r_index][cnt] <= ret_word;
        if (refill_done) tag_arr[victim][r_index] <= r_tag;
    end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: random CPU traffic and a memory-backed bridge, checked against
// a flat golden memory plus a tag/valid/dirty model of the cache.
module tb_cache_nway;
    localparam int WAYS = 2;
    localparam int SETS = 256;
    localparam int LW   = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_nway_if #(.SETS(SETS), .LINE_WORDS(LW)) bus();
    cache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct { bit op; bit unc; bit [31:0] addr; bit [3:0] strb; bit [31:0] data; } req_t;
    typedef struct { bit op; bit [31:0] data; } dok_t;
    typedef struct { bit [31:0] addr; bit [2:0] typ; } rd_t;
    typedef struct { bit [31:0] addr; bit [2:0] typ; bit [3:0] strb; bit [127:0] data; } wr_t;

    req_t req_q[$];
    dok_t dok_q[$];
    rd_t  rd_q[$];
    wr_t  wr_q[$];
    req_t cur;
    bit   have_req;
    bit [31:0] mem[bit [31:0]];
    bit [31:0] gold[bit [31:0]];
    bit [19:0] mtag[WAYS][SETS];
    bit        mv[WAYS][SETS];
    bit        md[WAYS][SETS];
    int        lfsr_m;
    bit        rd_act;
    int        beat, nbeats;
    bit [31:0] rd_base;
    int        checks = 0;
    int        failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] init_val(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic bit [31:0] rmem(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic bit [31:0] rgold(input bit [31:0] a);
        return gold.exists(a) ? gold[a] : init_val(a);
    endfunction
    function automatic bit [31:0] mrg(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
        bit [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return m;
    endfunction

    function automatic void step_lfsr();
        int fb;
        fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
        lfsr_m = ((lfsr_m << 1) | fb) & 'hFFFF;
    endfunction

    // Program-order model: every accepted request updates the golden view and
    // queues the bridge traffic and response it must produce.
    function automatic void model_accept(input req_t r);
        bit [19:0] t;
        bit [7:0]  idx;
        bit [31:0] wa, la, va;
        bit [127:0] ln;
        int hw, vw;
        dok_t d;
        rd_t  e;
        wr_t  w;
        t = r.addr[31:12]; idx = r.addr[11:4];
        wa = {r.addr[31:2], 2'b00}; la = {r.addr[31:4], 4'h0};
        d.op = r.op; d.data = 32'h0;
        if (r.unc) begin
            step_lfsr();
            if (r.op) begin
                w.addr = r.addr; w.typ = 3'b010; w.strb = r.strb; w.data = {96'h0, r.data};
                wr_q.push_back(w);
                gold[wa] = mrg(rgold(wa), r.data, r.strb);
            end else begin
                e.addr = r.addr; e.typ = 3'b010;
                rd_q.push_back(e);
                d.data = rgold(wa);
            end
            dok_q.push_back(d);
            return;
        end
        hw = -1;
        for (int i = 0; i < WAYS; i++) if (mv[i][idx] && mtag[i][idx] == t) hw = i;
        if (hw < 0) begin
            vw = lfsr_m % WAYS;
            step_lfsr();
            if (mv[vw][idx] && md[vw][idx]) begin
                va = {mtag[vw][idx], idx, 4'h0};
                for (int i = 0; i < LW; i++) ln[i*32 +: 32] = rgold(va + 32'(4 * i));
                w.addr = va; w.typ = 3'b100; w.strb = 4'hf; w.data = ln;
                wr_q.push_back(w);
            end
            e.addr = la; e.typ = 3'b100;
            rd_q.push_back(e);
            mtag[vw][idx] = t; mv[vw][idx] = 1'b1; md[vw][idx] = 1'b0;
            hw = vw;
        end
        if (r.op) begin
            gold[wa] = mrg(rgold(wa), r.data, r.strb);
            md[hw][idx] = 1'b1;
        end else begin
            d.data = rgold(wa);
        end
        dok_q.push_back(d);
    endfunction

    function automatic void clear_model();
        foreach (mv[w, s]) begin mv[w][s] = 1'b0; md[w][s] = 1'b0; end
        lfsr_m = 1;
        gold = mem;
        req_q.delete(); dok_q.delete(); rd_q.delete(); wr_q.delete();
        have_req = 1'b0; rd_act = 1'b0; beat = 0;
    endfunction

    function automatic req_t mk(input bit op, input bit unc, input bit [31:0] a, input bit [3:0] s, input bit [31:0] dt);
        req_t r;
        r.op = op; r.unc = unc; r.addr = a; r.strb = s; r.data = dt;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        bit [19:0] t;
        int k;
        r.op = 1'($urandom_range(0, 1));
        r.unc = $urandom_range(0, 9) == 0;
        r.strb = 4'($urandom_range(1, 15));
        r.data = $urandom;
        k = $urandom_range(0, 2);
        t = k == 0 ? 20'h12345 : k == 1 ? 20'h00ABC : 20'h07777;
        if (r.unc) r.addr = {20'h1FD00, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
        else r.addr = {t, 8'($urandom_range(5, 7)), 2'($urandom_range(0, 3)), 2'b00};
        return r;
    endfunction

    task automatic idle_inputs();
        bus.valid = 1'b0; bus.op = 1'b0; bus.uncached = 1'b0; bus.index = '0; bus.tag = '0;
        bus.offset = '0; bus.wstrb = '0; bus.wdata = '0; bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0;
        bus.ret_last = 1'b0; bus.ret_data = '0; bus.wr_rdy = 1'b0;
    endtask

    task automatic step();
        dok_t d;
        rd_t  e;
        wr_t  w;
        @(negedge clk);
        if (!have_req && req_q.size() > 0) begin cur = req_q.pop_front(); have_req = 1'b1; end
        bus.valid = have_req; bus.op = cur.op; bus.uncached = cur.unc;
        bus.tag = cur.addr[31:12]; bus.index = cur.addr[11:4]; bus.offset = cur.addr[3:0];
        bus.wstrb = cur.strb; bus.wdata = cur.data;
        bus.rd_rdy = 1'($urandom_range(0, 1));
        bus.wr_rdy = $urandom_range(0, 3) != 0;
        bus.ret_valid = rd_act && $urandom_range(0, 2) != 0;
        bus.ret_last = bus.ret_valid && beat == nbeats - 1;
        bus.ret_data = bus.ret_valid ? rmem(rd_base + 32'(4 * beat)) : 32'h0;
        #1;
        if (bus.addr_ok) begin
            check("addr_ok_without_valid", bus.valid, 1'b1);
            model_accept(cur);
            have_req = 1'b0;
        end
        if (bus.data_ok) begin
            if (dok_q.size() == 0) check("data_ok_unexpected", bus.data_ok, 1'b0);
            else begin
                d = dok_q.pop_front();
                if (!d.op) check("load_rdata", bus.rdata, d.data);
            end
        end
        if (bus.ret_valid) begin
            beat++;
            if (bus.ret_last) rd_act = 1'b0;
        end
        if (bus.rd_req && bus.rd_rdy) begin
            if (rd_q.size() == 0) check("rd_req_unexpected", bus.rd_req, 1'b0);
            else begin
                e = rd_q.pop_front();
                check("rd_addr", bus.rd_addr, e.addr);
                check("rd_type", bus.rd_type, e.typ);
            end
            rd_act = 1'b1; beat = 0;
            nbeats = bus.rd_type == 3'b100 ? LW : 1;
            rd_base = bus.rd_type == 3'b100 ? bus.rd_addr : {bus.rd_addr[31:2], 2'b00};
        end
        if (bus.wr_req) begin
            if (wr_q.size() == 0) check("wr_req_unexpected", bus.wr_req, 1'b0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", bus.wr_addr, w.addr);
                check("wr_type", bus.wr_type, w.typ);
                check("wr_wstrb", bus.wr_wstrb, w.strb);
                check("wr_data", bus.wr_data, w.data);
            end
            if (bus.wr_type == 3'b100)
                for (int i = 0; i < LW; i++) mem[bus.wr_addr + 32'(4 * i)] = bus.wr_data[i*32 +: 32];
            else
                mem[{bus.wr_addr[31:2], 2'b00}] = mrg(rmem({bus.wr_addr[31:2], 2'b00}), bus.wr_data[31:0], bus.wr_wstrb);
        end
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((req_q.size() > 0 || have_req || dok_q.size() > 0 || rd_q.size() > 0 ||
                wr_q.size() > 0 || rd_act) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_outstanding"}, dok_q.size() + rd_q.size() + wr_q.size() + req_q.size(), 0);
    endtask

    initial begin
        int n;
        idle_inputs();
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("rst_addr_ok", bus.addr_ok, 1'b0);
        check("rst_data_ok", bus.data_ok, 1'b0);
        check("rst_rd_req", bus.rd_req, 1'b0);
        check("rst_wr_req", bus.wr_req, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        req_q.push_back(mk(1'b0, 1'b0, 32'h1234_5050, 4'h0, 32'h0));
        drain("first_miss", 500);
        req_q.push_back(mk(1'b0, 1'b0, 32'h1234_5050, 4'h0, 32'h0));
        req_q.push_back(mk(1'b0, 1'b0, 32'h1234_5058, 4'h0, 32'h0));
        drain("b2b_hits", 500);
        req_q.push_back(mk(1'b1, 1'b0, 32'h1234_5050, 4'b0011, 32'hDEAD_BEEF));
        req_q.push_back(mk(1'b0, 1'b0, 32'h1234_5050, 4'h0, 32'h0));
        drain("store_load_conflict", 500);
        req_q.push_back(mk(1'b0, 1'b0, 32'h00AB_C054, 4'h0, 32'h0));
        req_q.push_back(mk(1'b1, 1'b0, 32'h00AB_C054, 4'hf, 32'h1111_2222));
        req_q.push_back(mk(1'b0, 1'b0, 32'h0777_7050, 4'h0, 32'h0));
        req_q.push_back(mk(1'b0, 1'b0, 32'h00AB_C054, 4'h0, 32'h0));
        drain("dirty_victim", 1000);
        req_q.push_back(mk(1'b1, 1'b1, 32'h1FD0_0000, 4'hf, 32'hCAFE_F00D));
        req_q.push_back(mk(1'b0, 1'b1, 32'h1FD0_0000, 4'h0, 32'h0));
        drain("uncached", 500);

        for (int i = 0; i < 400; i++) req_q.push_back(rand_req());
        drain("random", 20000);

        // Reset while the third beat of a line refill is still pending.
        req_q.push_back(mk(1'b0, 1'b0, 32'h0BEE_F09C, 4'h0, 32'h0));
        n = 0;
        while (!(rd_act && beat == 2) && n < 500) begin step(); n++; end
        check("refill_reached_beat2", beat, 2);
        idle_inputs();
        resetn = 1'b0;
        #1;
        check("midrst_addr_ok", bus.addr_ok, 1'b0);
        check("midrst_data_ok", bus.data_ok, 1'b0);
        check("midrst_rd_req", bus.rd_req, 1'b0);
        check("midrst_wr_req", bus.wr_req, 1'b0);
        check("midrst_rdata", bus.rdata, 32'h0);
        clear_model();
        @(negedge clk);
        resetn = 1'b1;
        req_q.push_back(mk(1'b0, 1'b0, 32'h0BEE_F09C, 4'h0, 32'h0));
        drain("post_reset_miss", 500);
        for (int i = 0; i < 60; i++) req_q.push_back(rand_req());
        drain("post_reset_random", 4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
